// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared types and field positions for the control packet decoder
//
// Holds the opcode and compute-type enums, the decoded control and raw packet
// structs, and the bit positions of every packet field.

package accel_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2,
        OP_COMP  = 2'd3
    } op_code_t;

    typedef enum logic [1:0] {
        COMP_ADD  = 2'd0,
        COMP_MUL  = 2'd1,
        COMP_TANH = 2'd2,
        COMP_RELU = 2'd3
    } comp_type_t;

    typedef struct packed {
        op_code_t   op_code;
        comp_type_t comp_type;
        logic [3:0] addr;
        logic [3:0] tag;
    } control_signal_t;

    typedef struct packed {
        logic [7:0] encoded_control;
        logic [7:0] data_control;
    } control_packet_t;

    // Positions inside the encoded byte
    localparam int ENC_OP_HI   = 7;
    localparam int ENC_OP_LO   = 6;
    localparam int ENC_COMP_HI = 5;
    localparam int ENC_COMP_LO = 4;
    localparam int ENC_ADDR_HI = 3;
    localparam int ENC_ADDR_LO = 0;

    // Positions inside the data byte
    localparam int DATA_STROBE = 7;
    localparam int DATA_PARITY = 6;
    localparam int DATA_RSV_HI = 5;
    localparam int DATA_RSV_LO = 4;
    localparam int DATA_TAG_HI = 3;
    localparam int DATA_TAG_LO = 0;

endpackage

// File: rtl/ctrl_parity_chk.sv
// rtl/ctrl_parity_chk.sv - combinational even-parity check of the encoded control byte
//
// Built only when DECODER_PARITY_EN is defined.
// Ports:
//   data_i    in  8  encoded control byte
//   parity_i  in  1  parity bit carried in the packet
//   par_err_o out 1  high when parity_i differs from the XOR of data_i

`ifdef DECODER_PARITY_EN
module ctrl_parity_chk (
    input  logic [7:0] data_i,
    input  logic       parity_i,
    output logic       par_err_o
);

    assign par_err_o = parity_i ^ (^data_i);

endmodule
`endif

// File: rtl/optimized_decoder.sv
// rtl/optimized_decoder.sv - registered parity/legality decoder for per-unit control packets
//
// Configuration macro: DECODER_PARITY_EN (parity check built when defined,
// otherwise the parity bit is ignored and error_status[0] is always 0).
// Ports:
//   clk              in  1                 clock, rising edge
//   rst_n            in  1                 asynchronous active-low reset
//   encoded_control  in  16                {enc[7:0], data[7:0]} packet
//   decoded_control  out control_signal_t  last legal decoded command
//   decode_valid     out 1                 decoded_control reflects a legal strobed packet
//   error_status     out 2                 [0] parity error, [1] illegal encoding

module optimized_decoder
    import accel_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     encoded_control,
    output control_signal_t decoded_control,
    output logic            decode_valid,
    output logic [1:0]      error_status
);

    control_packet_t pkt;
    control_signal_t fields;
    logic            strobe;
    logic            par_err;
    logic            ill_err;

    control_signal_t ctrl_d, ctrl_q;
    logic            valid_d, valid_q;
    logic [1:0]      err_d, err_q;

    assign pkt    = control_packet_t'(encoded_control);
    assign strobe = pkt.data_control[DATA_STROBE];

`ifdef DECODER_PARITY_EN
    ctrl_parity_chk u_parity_chk (
        .data_i    (pkt.encoded_control),
        .parity_i  (pkt.data_control[DATA_PARITY]),
        .par_err_o (par_err)
    );
`else
    logic unused_parity_bit;
    assign unused_parity_bit = pkt.data_control[DATA_PARITY];
    assign par_err           = 1'b0;
`endif

    always_comb begin
        fields.op_code   = op_code_t'(pkt.encoded_control[ENC_OP_HI:ENC_OP_LO]);
        fields.comp_type = comp_type_t'(pkt.encoded_control[ENC_COMP_HI:ENC_COMP_LO]);
        fields.addr      = pkt.encoded_control[ENC_ADDR_HI:ENC_ADDR_LO];
        fields.tag       = pkt.data_control[DATA_TAG_HI:DATA_TAG_LO];
    end

    // A compute type only means something for OP_COMP, and a NOP carries no address.
    assign ill_err = (pkt.data_control[DATA_RSV_HI:DATA_RSV_LO] != 2'b00)
                   | ((fields.op_code != OP_COMP) && (fields.comp_type != COMP_ADD))
                   | ((fields.op_code == OP_NOP) && (fields.addr != 4'd0));

    // Level-sensitive: every edge with strobe high re-decodes the present packet.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = 1'b0;
        err_d   = 2'b00;
        if (strobe) begin
            err_d = {ill_err, par_err};
            if (!ill_err && !par_err) begin
                ctrl_d  = fields;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign decoded_control = ctrl_q;
    assign decode_valid    = valid_q;
    assign error_status    = err_q;

endmodule

// File: tb/tb_optimized_decoder.sv
// tb/tb_optimized_decoder.sv - scoreboard bench for optimized_decoder with a field-level reference model

module tb_optimized_decoder;
    import accel_pkg::*;

`ifdef DECODER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     encoded_control = 16'h0000;
    control_signal_t decoded_control;
    logic            decode_valid;
    logic [1:0]      error_status;

    always #5 clk = ~clk;

    optimized_decoder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .encoded_control (encoded_control),
        .decoded_control (decoded_control),
        .decode_valid    (decode_valid),
        .error_status    (error_status)
    );

    typedef struct {
        logic [11:0] ctrl;
        logic        valid;
        logic [1:0]  err;
        logic [15:0] pkt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [11:0] m_ctrl  = '0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_err   = 2'b00;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: splits the packet with plain arithmetic and applies the decode rules.
    task automatic model_step(input logic [15:0] pkt);
        int  enc, dat, op, comp, addr, strobe, par, rsv, tag;
        bit  pe, ie;
        exp_t e;
        enc    = int'(pkt[15:8]);
        dat    = int'(pkt[7:0]);
        op     = enc / 64;
        comp   = (enc / 16) % 4;
        addr   = enc % 16;
        strobe = dat / 128;
        par    = (dat / 64) % 2;
        rsv    = (dat / 16) % 4;
        tag    = dat % 16;
        pe     = PAR_EN && (par != ($countones(enc) % 2));
        ie     = (rsv != 0) || (op != 3 && comp != 0) || (op == 0 && addr != 0);
        if (strobe == 0) begin
            m_valid = 1'b0;
            m_err   = 2'b00;
        end else begin
            m_err = {ie, pe};
            if (!ie && !pe) begin
                m_ctrl  = 12'(op * 1024 + comp * 256 + addr * 16 + tag);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        e.ctrl  = m_ctrl;
        e.valid = m_valid;
        e.err   = m_err;
        e.pkt   = pkt;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [15:0] pkt);
        @(negedge clk);
        rst_n           = 1'b1;
        encoded_control = pkt;
        model_step(pkt);
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl",  {4'h0, 12'(decoded_control)}, 16'h0000);
        check("async_reset_valid", {15'h0, decode_valid},        16'h0000);
        check("async_reset_err",   {14'h0, error_status},        16'h0000);
        m_ctrl  = '0;
        m_valid = 1'b0;
        m_err   = 2'b00;
        @(posedge clk);
        #1;
        check("held_reset_valid", {15'h0, decode_valid}, 16'h0000);
    endtask

    // Monitor: one output word per edge while out of reset.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl",  {4'h0, 12'(decoded_control)}, {4'h0, e.ctrl});
            check("valid", {15'h0, decode_valid},        {15'h0, e.valid});
            check("err",   {14'h0, error_status},        {14'h0, e.err});
        end
    end

    function automatic logic [15:0] rand_pkt();
        int op, comp, addr, strobe, rsv, tag, par;
        op     = int'($urandom_range(0, 3));
        comp   = (op == 3 || $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0;
        addr   = (op != 0 || $urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 0;
        strobe = ($urandom_range(0, 4) != 0) ? 1 : 0;
        rsv    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : 0;
        tag    = int'($urandom_range(0, 15));
        par    = ($countones(op * 64 + comp * 16 + addr) % 2) ^ (($urandom_range(0, 7) == 0) ? 1 : 0);
        return 16'((op * 64 + comp * 16 + addr) * 256 + strobe * 128 + par * 64 + rsv * 16 + tag);
    endfunction

    initial begin
        logic [15:0] last;
        repeat (2) @(negedge clk);
        check("reset_valid", {15'h0, decode_valid}, 16'h0000);

        drive(16'h0000);
        drive(16'h45C3);
        do_reset();

        drive(16'h45C3);
        drive(16'h4543);
        repeat (3) drive(16'hD0C0);
        drive(16'h4583);
        drive(16'hA2C0);
        drive(16'h45B0);
        drive(16'h45C3);
        drive(16'h82C1);
        drive(16'h82C0);
        drive(16'h0080);
        drive(16'h0180);

        last = 16'h0000;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 9) >= 3) last = rand_pkt();
            drive(last);
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
